// File: rtl/execute_stage_if.sv
// Decode-to-execute inputs, control inputs and all execute/memory-side outputs
// of the execute stage, bundled as one bus.
interface execute_stage_if;
  logic [2:0]  d_stat;
  logic [3:0]  d_icode, d_ifun;
  logic [63:0] d_valC, d_valA, d_valB;
  logic [3:0]  d_dstE, d_dstM;
  logic        E_bubble, M_bubble, set_cc_en;
  logic [63:0] e_valE;
  logic [3:0]  e_dstE;
  logic        e_Cnd;
  logic [3:0]  E_icode, E_dstM;
  logic [2:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valE, M_valA;
  logic [3:0]  M_dstE, M_dstM;
  logic        cc_zf, cc_sf, cc_of;

  modport master (
    output d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB, d_dstE, d_dstM,
    output E_bubble, M_bubble, set_cc_en,
    input  e_valE, e_dstE, e_Cnd, E_icode, E_dstM,
    input  M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM,
    input  cc_zf, cc_sf, cc_of
  );

  modport slave (
    input  d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB, d_dstE, d_dstM,
    input  E_bubble, M_bubble, set_cc_en,
    output e_valE, e_dstE, e_Cnd, E_icode, E_dstM,
    output M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM,
    output cc_zf, cc_sf, cc_of
  );
endinterface

// File: rtl/execute_stage.sv
// Y86-64 execute stage: D->E register, ALU, condition codes, Cnd evaluation,
// E->M register. e_valE/e_dstE/e_Cnd are combinational for forwarding.

// 64-bit ALU; OF is signed overflow for add/sub and forced low for logic ops.
module alu (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [1:0]  fn,
  output logic [63:0] y,
  output logic        of
);
  // result and overflow from operand signs
  always_comb begin
    y  = '0;
    of = 1'b0;
    case (fn)
      2'd0: begin y = a + b; of = (a[63] == b[63]) && (y[63] != a[63]); end
      2'd1: begin y = a - b; of = (a[63] != b[63]) && (y[63] != a[63]); end
      2'd2: y = a & b;
      default: y = a ^ b;
    endcase
  end
endmodule

module execute_stage #(
  parameter logic [3:0] RNONE     = 4'hF,
  parameter logic [3:0] NOP_ICODE = 4'h1,
  parameter logic [2:0] SAOK      = 3'd1
) (
  input logic          clk,
  input logic          rst_n,
  execute_stage_if.slave bus
);
  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode, ifun;
    logic [63:0] valC, valA, valB;
    logic [3:0]  dstE, dstM;
  } e_reg_t;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] valE, valA;
    logic [3:0]  dstE, dstM;
  } m_reg_t;

  localparam e_reg_t E_NOP = '{stat: SAOK, icode: NOP_ICODE, ifun: 4'h0,
                               valC: 64'd0, valA: 64'd0, valB: 64'd0,
                               dstE: RNONE, dstM: RNONE};
  localparam m_reg_t M_NOP = '{stat: SAOK, icode: NOP_ICODE, cnd: 1'b0,
                               valE: 64'd0, valA: 64'd0,
                               dstE: RNONE, dstM: RNONE};

  e_reg_t      e_q;
  m_reg_t      m_q;
  logic [63:0] alu_a, alu_b, alu_y;
  logic [1:0]  alu_fn;
  logic        alu_of;
  logic        zf, sf, of, cnd, set_cc;
  logic [3:0]  dst_e;

  // D->E pipeline register; a bubble replaces the incoming instruction with a nop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            e_q <= E_NOP;
    else if (bus.E_bubble) e_q <= E_NOP;
    else e_q <= '{stat: bus.d_stat, icode: bus.d_icode, ifun: bus.d_ifun,
                  valC: bus.d_valC, valA: bus.d_valA, valB: bus.d_valB,
                  dstE: bus.d_dstE, dstM: bus.d_dstM};
  end

  // operand routing by instruction class
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_fn = 2'd0;
    case (e_q.icode)
      4'h2:       alu_a = e_q.valA;
      4'h3:       alu_a = e_q.valC;
      4'h4, 4'h5: begin alu_a = e_q.valB; alu_b = e_q.valC; end
      4'h6:       begin alu_a = e_q.valB; alu_b = e_q.valA; alu_fn = e_q.ifun[1:0]; end
      4'h8, 4'hA: begin alu_a = e_q.valB; alu_b = 64'hFFFF_FFFF_FFFF_FFF8; end
      4'h9, 4'hB: begin alu_a = e_q.valB; alu_b = 64'd8; end
      default: ;
    endcase
  end

  alu u_alu (.a(alu_a), .b(alu_b), .fn(alu_fn), .y(alu_y), .of(alu_of));

  // only a healthy OPq writes CC, and only when the hazard unit allows it
  assign set_cc = (e_q.icode == 4'h6) && bus.set_cc_en && (e_q.stat == SAOK);

  // condition-code register, reset to "last result was zero"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf <= 1'b1; sf <= 1'b0; of <= 1'b0;
    end else if (set_cc) begin
      zf <= (alu_y == 64'd0);
      sf <= alu_y[63];
      of <= alu_of;
    end
  end

  // branch/move condition from the CC value held before this edge
  always_comb begin
    cnd = 1'b0;
    case (e_q.ifun)
      4'h0: cnd = 1'b1;
      4'h1: cnd = (sf ^ of) | zf;
      4'h2: cnd = sf ^ of;
      4'h3: cnd = zf;
      4'h4: cnd = ~zf;
      4'h5: cnd = ~(sf ^ of);
      4'h6: cnd = ~(sf ^ of) & ~zf;
      default: cnd = 1'b0;
    endcase
  end

  // a failed cmov writes nowhere
  assign dst_e = ((e_q.icode == 4'h2) && !cnd) ? RNONE : e_q.dstE;

  // E->M pipeline register; a bubble drops the execute result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            m_q <= M_NOP;
    else if (bus.M_bubble) m_q <= M_NOP;
    else m_q <= '{stat: e_q.stat, icode: e_q.icode, cnd: cnd, valE: alu_y,
                  valA: e_q.valA, dstE: dst_e, dstM: e_q.dstM};
  end

  assign bus.e_valE  = alu_y;
  assign bus.e_dstE  = dst_e;
  assign bus.e_Cnd   = cnd;
  assign bus.E_icode = e_q.icode;
  assign bus.E_dstM  = e_q.dstM;
  assign bus.M_stat  = m_q.stat;
  assign bus.M_icode = m_q.icode;
  assign bus.M_Cnd   = m_q.cnd;
  assign bus.M_valE  = m_q.valE;
  assign bus.M_valA  = m_q.valA;
  assign bus.M_dstE  = m_q.dstE;
  assign bus.M_dstM  = m_q.dstM;
  assign bus.cc_zf   = zf;
  assign bus.cc_sf   = sf;
  assign bus.cc_of   = of;
endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the pipelined Y86-64 processor. It holds the D→E pipeline register, builds operands for an internal `ALU` instance, and maintains the condition-code register (ZF/SF/OF). It evaluates the branch/move condition and holds the E→M pipeline register. It also exports the combinational `e_valE`/`e_dstE` for forwarding and the `e_Cnd` result for branch-misprediction detection.

## Interface
Parameters:
- `RNONE`, 4'hF: register ID meaning "no destination".
- `NOP_ICODE`, 4'h1: icode loaded on bubble or reset.
- `SAOK`, 3'd1: status code AOK. Other codes: HLT=2, ADR=3, INS=4.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `d_stat` in 3, `d_icode` in 4, `d_ifun` in 4: decode-stage outputs.
- `d_valC` in 64, `d_valA` in 64, `d_valB` in 64: decode-stage operand values.
- `d_dstE` in 4, `d_dstM` in 4: decode-stage destination register IDs.
- `E_bubble` in 1: load a nop into the E register at the next edge.
- `M_bubble` in 1: load a nop into the M register at the next edge.
- `set_cc_en` in 1: hazard-unit permit for a CC write. It is low while an exception sits in M or W.
- `e_valE` out 64: combinational ALU result.
- `e_dstE` out 4: combinational destination after the cmov qualification.
- `e_Cnd` out 1: combinational condition result.
- `E_icode` out 4: current E-register icode, for the hazard unit.
- `E_dstM` out 4: current E-register dstM, for the hazard unit.
- `M_stat` out 3, `M_icode` out 4, `M_Cnd` out 1: E→M register outputs.
- `M_valE` out 64, `M_valA` out 64: E→M register data outputs.
- `M_dstE` out 4, `M_dstM` out 4: E→M register destination outputs.
- `cc_zf` out 1, `cc_sf` out 1, `cc_of` out 1: architectural condition codes.

## Operation
**ALU operand selection.** `ALU` port A minus/op port B, by `E_icode`:
- 2 (rrmovq/cmovXX): A=valA, B=0, add.
- 3 (irmovq): A=valC, B=0, add.
- 4, 5 (rmmovq, mrmovq): A=valB, B=valC, add.
- 6 (OPq): A=valB, B=valA, sel=ifun[1:0] (0 add, 1 sub, 2 and, 3 xor). The result is valB OP valA.
- 8, A (call, pushq): A=valB, B=-8 (64'hFFFF_FFFF_FFFF_FFF8), add.
- 9, B (ret, popq): A=valB, B=8, add.
- All other icodes: A=0, B=0, add.

**CC update.**
- CC is written at the clock edge only when all hold: E_icode=6, `set_cc_en`=1, and E_stat=SAOK.
- ZF = (e_valE==0).
- SF = e_valE[63].
- OF = ALU Overflow. The ALU forces OF to 0 for and/xor.

**Cnd.** Computed from the current CC register (pre-update), by E_ifun:
- 0: 1.
- 1 (le): (SF^OF)|ZF.
- 2 (l): SF^OF.
- 3 (e): ZF.
- 4 (ne): !ZF.
- 5 (ge): !(SF^OF).
- 6 (g): !(SF^OF)&!ZF.
- 7–F: 0.

**e_dstE.** If E_icode=2 and e_Cnd=0, e_dstE=RNONE; otherwise e_dstE=E_dstE.

**E→M capture.** M_valA takes E_valA. Stat, icode, and dstM pass through. M_Cnd takes e_Cnd.

## Timing
**Latency.** A d_* value presented before edge N appears on `E_*` after edge N. The resulting `e_valE`, `e_dstE`, and `e_Cnd` are valid combinationally in the same cycle. They appear on `M_*` after edge N+1.

**Reset.** `rst_n`=0 clears immediately, with no clock required. This applies mid-operation as well.
- E and M registers hold nop values: stat=SAOK, icode=1, ifun=0, all data=0, dst=RNONE, M_Cnd=0.
- CC resets to ZF=1, SF=0, OF=0.
- On the first edge after release, normal capture resumes.

**Bubble.**
- `E_bubble`=1 loads the E register with nop values at the edge. The d_* inputs are discarded.
- `M_bubble`=1 loads the M register with nop values at the edge. The e_* results are discarded.
- When both are asserted, both are applied independently in the same edge.
- A bubble never blocks a CC update: the CC write decision uses the E contents before the edge.

**Other edge cases.**
- The 64-bit arithmetic wraps modulo 2^64.
- There is no stall input. The E register loads every edge unless bubbled.

## Test plan
- **subq.** E holds OPq ifun1, valA=5, valB=3, set_cc_en=1 → e_valE=64'hFFFF_FFFF_FFFF_FFFE. Next edge: M_valE matches, ZF=0, SF=1, OF=0.
- **addq overflow.** valB=64'h7FFF_FFFF_FFFF_FFFF, valA=1 → e_valE=64'h8000_0000_0000_0000. After the edge: OF=1, SF=1, ZF=0. Repeating with set_cc_en=0 leaves CC unchanged.
- **cmovle / jle.** With CC ZF=0, SF=1, OF=0: cmovle (icode2 ifun1) dstE=3 → e_Cnd=1, e_dstE=3. With SF=0: e_Cnd=0, e_dstE=4'hF. jle (icode7 ifun1) → M_Cnd equals e_Cnd, and CC is unchanged.
- **Stack ops.** pushq with valB=0x100 → e_valE=0xF8. popq with valB=0x100 → e_valE=0x108. mrmovq with valB=0x40, valC=0x10 → 0x50.
- **Bubbles.** Assert E_bubble with d_icode=6 → after the edge E_icode=1 and CC is not updated next cycle. Assert E_bubble and M_bubble together → M_icode=1, M_dstE=4'hF.
- **Async reset.** Pull rst_n low mid-cycle while M holds a subq → M_icode=1, M_stat=1, M_valE=0 and ZF=1, SF=0, OF=0 immediately, before the next clock edge.
